// File: rtl/rvfi_retire_serializer.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_retire_serializer
// Purpose  : Collects every valid multi-channel RVFI retirement each cycle,
//            compacts the valid channels in ascending channel order into a
//            circular FIFO and replays them one per cycle on a single RVFI
//            channel with ready/valid flow control. A retirement group that
//            does not fit is dropped whole and flagged on a sticky overflow.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN  : register / PC width
//   NRET  : number of input retirement channels (1..4)
//   DEPTH : FIFO entries, power of two, >= NRET
// Ports
//   clock, resetn        : clock and asynchronous active-low reset
//   in_valid [NRET]      : per-channel retire strobe
//   in_order .. in_intr  : per-channel RVFI fields, channel i at [i*W +: W]
//   out_valid/out_ready  : single-channel handshake for the FIFO head
//   out_order .. out_intr: RVFI fields of the FIFO head
//   level                : number of occupied entries (0..DEPTH)
//   overflow             : sticky, a retirement group was dropped
//   order_error          : sticky, accepted orders were not consecutive
// Configuration
//   RVFI_SERIALIZE_ORDER_CHECK_EN : when defined, compiles in the order
//   continuity checker and the order_error port.
// ============================================================================
module rvfi_retire_serializer #(
    parameter int XLEN  = 32,
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NRET-1:0]         in_valid,
    input  logic [NRET*64-1:0]      in_order,
    input  logic [NRET*32-1:0]      in_insn,
    input  logic [NRET*XLEN-1:0]    in_pc_rdata,
    input  logic [NRET*XLEN-1:0]    in_pc_wdata,
    input  logic [NRET*5-1:0]       in_rd_addr,
    input  logic [NRET*XLEN-1:0]    in_rd_wdata,
    input  logic [NRET-1:0]         in_trap,
    input  logic [NRET-1:0]         in_halt,
    input  logic [NRET-1:0]         in_intr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_order,
    output logic [31:0]             out_insn,
    output logic [XLEN-1:0]         out_pc_rdata,
    output logic [XLEN-1:0]         out_pc_wdata,
    output logic [4:0]              out_rd_addr,
    output logic [XLEN-1:0]         out_rd_wdata,
    output logic                    out_trap,
    output logic                    out_halt,
    output logic                    out_intr,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
`ifdef RVFI_SERIALIZE_ORDER_CHECK_EN
    ,
    output logic                    order_error
`endif
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int AW      = $clog2(DEPTH);       // storage index width
    localparam int PW      = AW + 1;              // pointer width (extra wrap bit)
    localparam int CW      = PW + 1;              // count width, holds DEPTH+1
    localparam int ENTRY_W = 64 + 32 + 3*XLEN + 5 + 3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic               overflow_q, overflow_d;

    // Storage is deliberately not reset; emptiness is tracked by the pointers.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [PW-1:0]      w_level;
    logic               w_pop;
    logic [CW-1:0]      w_push_cnt;
    logic [CW-1:0]      w_free;
    logic               w_accept;
    logic [NRET-1:0]    w_wen;
    logic [AW-1:0]      w_slot  [NRET];
    logic [ENTRY_W-1:0] w_entry [NRET];
    logic [ENTRY_W-1:0] w_head;

    // Pointer difference is the occupancy; the extra MSB disambiguates
    // full (DEPTH) from empty (0) when the index bits coincide.
    assign w_level   = wptr_q - rptr_q;
    assign level     = w_level;
    assign out_valid = (w_level != '0);
    assign w_pop     = out_valid & out_ready;
    assign overflow  = overflow_q;

    // ------------------------------------------------------------------------
    // Pack each input channel into a storage entry
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_pack
            assign w_entry[gi] = {
                in_order   [gi*64   +: 64],
                in_insn    [gi*32   +: 32],
                in_pc_rdata[gi*XLEN +: XLEN],
                in_pc_wdata[gi*XLEN +: XLEN],
                in_rd_addr [gi*5    +: 5],
                in_rd_wdata[gi*XLEN +: XLEN],
                in_trap[gi],
                in_halt[gi],
                in_intr[gi]
            };
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Compaction: each valid channel lands at wptr + (number of valid
    // channels below it), which squeezes out gaps in in_valid.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NRET; i++) begin
            w_slot[i] = wptr_q[AW-1:0] + AW'(cnt);
            cnt       = cnt + CW'(in_valid[i]);
        end
        w_push_cnt = cnt;
    end

    // A slot freed by this cycle's pop is usable by this cycle's push.
    assign w_free   = CW'(DEPTH) - CW'(w_level) + CW'(w_pop);

    // All-or-nothing: a group that does not fit is dropped entirely.
    assign w_accept = (w_push_cnt <= w_free);

    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_wen
            assign w_wen[gi] = in_valid[gi] & w_accept;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pointer and flag next-state
    // ------------------------------------------------------------------------
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (w_accept) begin
            wptr_d = wptr_q + w_push_cnt[PW-1:0];
        end else begin
            overflow_d = 1'b1;
        end
        if (w_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage write; accepted channels always target distinct slots.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int i = 0; i < NRET; i++) begin
            if (w_wen[i]) begin
                mem_q[w_slot[i]] <= w_entry[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Head read is combinational so a pushed entry is visible one edge later.
    // ------------------------------------------------------------------------
    assign w_head = mem_q[rptr_q[AW-1:0]];

    assign {out_order, out_insn, out_pc_rdata, out_pc_wdata,
            out_rd_addr, out_rd_wdata, out_trap, out_halt, out_intr} = w_head;

`ifdef RVFI_SERIALIZE_ORDER_CHECK_EN
    // ------------------------------------------------------------------------
    // Order continuity checker. Accepted entries are examined in compaction
    // order, so within a group each channel is compared to the one below it.
    // ------------------------------------------------------------------------
    logic [63:0] last_order_q, last_order_d;
    logic        seen_q, seen_d;
    logic        order_error_q, order_error_d;

    always_comb begin
        last_order_d  = last_order_q;
        seen_d        = seen_q;
        order_error_d = order_error_q;
        for (int i = 0; i < NRET; i++) begin
            if (w_wen[i]) begin
                if (seen_d && (in_order[i*64 +: 64] != last_order_d + 64'd1)) begin
                    order_error_d = 1'b1;
                end
                last_order_d = in_order[i*64 +: 64];
                seen_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_order_q  <= '0;
            seen_q        <= 1'b0;
            order_error_q <= 1'b0;
        end else begin
            last_order_q  <= last_order_d;
            seen_q        <= seen_d;
            order_error_q <= order_error_d;
        end
    end

    assign order_error = order_error_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvfi_retire_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvfi_retire_serializer
// Purpose  : Self-checking bench for rvfi_retire_serializer. A queue-based
//            reference model is updated on every clock edge from the driven
//            inputs; a monitor compares the DUT outputs against the model at
//            each falling edge. Directed scenarios are followed by random
//            traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvfi_retire_serializer;

    localparam int XLEN  = 32;
    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic                   clock  = 1'b0;
    logic                   resetn = 1'b0;
    logic [NRET-1:0]        in_valid    = '0;
    logic [NRET*64-1:0]     in_order    = '0;
    logic [NRET*32-1:0]     in_insn     = '0;
    logic [NRET*XLEN-1:0]   in_pc_rdata = '0;
    logic [NRET*XLEN-1:0]   in_pc_wdata = '0;
    logic [NRET*5-1:0]      in_rd_addr  = '0;
    logic [NRET*XLEN-1:0]   in_rd_wdata = '0;
    logic [NRET-1:0]        in_trap = '0;
    logic [NRET-1:0]        in_halt = '0;
    logic [NRET-1:0]        in_intr = '0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [63:0]            out_order;
    logic [31:0]            out_insn;
    logic [XLEN-1:0]        out_pc_rdata, out_pc_wdata, out_rd_wdata;
    logic [4:0]             out_rd_addr;
    logic                   out_trap, out_halt, out_intr;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
`ifdef RVFI_SERIALIZE_ORDER_CHECK_EN
    logic                   order_error;
`endif

    rvfi_retire_serializer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_order    (in_order),
        .in_insn     (in_insn),
        .in_pc_rdata (in_pc_rdata),
        .in_pc_wdata (in_pc_wdata),
        .in_rd_addr  (in_rd_addr),
        .in_rd_wdata (in_rd_wdata),
        .in_trap     (in_trap),
        .in_halt     (in_halt),
        .in_intr     (in_intr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_order   (out_order),
        .out_insn    (out_insn),
        .out_pc_rdata(out_pc_rdata),
        .out_pc_wdata(out_pc_wdata),
        .out_rd_addr (out_rd_addr),
        .out_rd_wdata(out_rd_wdata),
        .out_trap    (out_trap),
        .out_halt    (out_halt),
        .out_intr    (out_intr),
        .level       (level),
        .overflow    (overflow)
`ifdef RVFI_SERIALIZE_ORDER_CHECK_EN
        ,
        .order_error (order_error)
`endif
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Counters and compare helper
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a queue of retirements in expected output order
    // ------------------------------------------------------------------------
    typedef struct {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic [XLEN-1:0] pcr;
        logic [XLEN-1:0] pcw;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdw;
        logic            trap;
        logic            halt;
        logic            intr;
    } ent_t;

    ent_t        q[$];
    bit          ov_m   = 1'b0;
    bit          err_m  = 1'b0;
    bit          seen_m = 1'b0;
    logic [63:0] last_m = '0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            ov_m   = 1'b0;
            err_m  = 1'b0;
            seen_m = 1'b0;
        end else begin
            int   cnt;
            int   free;
            bit   pop;
            ent_t e;
            pop  = (q.size() != 0) && out_ready;
            cnt  = 0;
            for (int i = 0; i < NRET; i++) cnt += int'(in_valid[i]);
            free = DEPTH - q.size() + int'(pop);
            if (pop) void'(q.pop_front());
            if (cnt > free) begin
                ov_m = 1'b1;
            end else begin
                for (int i = 0; i < NRET; i++) begin
                    if (in_valid[i]) begin
                        e.order = in_order[i*64 +: 64];
                        e.insn  = in_insn[i*32 +: 32];
                        e.pcr   = in_pc_rdata[i*XLEN +: XLEN];
                        e.pcw   = in_pc_wdata[i*XLEN +: XLEN];
                        e.rd    = in_rd_addr[i*5 +: 5];
                        e.rdw   = in_rd_wdata[i*XLEN +: XLEN];
                        e.trap  = in_trap[i];
                        e.halt  = in_halt[i];
                        e.intr  = in_intr[i];
                        if (seen_m && e.order != last_m + 64'd1) err_m = 1'b1;
                        last_m = e.order;
                        seen_m = 1'b1;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: compare DUT outputs with the model away from the active edge
    // ------------------------------------------------------------------------
    always @(negedge clock) begin
        if (resetn) begin
            chk("out_valid", 192'(out_valid), 192'(q.size() != 0));
            chk("level", 192'(level), 192'(q.size()));
            chk("overflow", 192'(overflow), 192'(ov_m));
`ifdef RVFI_SERIALIZE_ORDER_CHECK_EN
            chk("order_error", 192'(order_error), 192'(err_m));
`endif
            if (out_valid && q.size() != 0) begin
                chk("head_order", 192'(out_order), 192'(q[0].order));
                chk("head_fields",
                    192'({out_insn, out_pc_rdata, out_pc_wdata, out_rd_addr,
                          out_rd_wdata, out_trap, out_halt, out_intr}),
                    192'({q[0].insn, q[0].pcr, q[0].pcw, q[0].rd,
                          q[0].rdw, q[0].trap, q[0].halt, q[0].intr}));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers; each call occupies one clock cycle and returns just
    // after the following falling edge.
    // ------------------------------------------------------------------------
    task automatic drive(input logic [1:0] v, input logic [63:0] o0,
                         input logic [63:0] o1, input logic rdy);
        in_valid    = v;
        in_order    = {o1, o0};
        in_insn     = {$urandom(), $urandom()};
        in_pc_rdata = {$urandom(), $urandom()};
        in_pc_wdata = {$urandom(), $urandom()};
        in_rd_addr  = 10'($urandom());
        in_rd_wdata = {$urandom(), $urandom()};
        in_trap     = 2'($urandom());
        in_halt     = 2'($urandom());
        in_intr     = 2'($urandom());
        out_ready   = rdy;
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(2'b00, 64'd0, 64'd0, rdy);
    endtask

    task automatic do_reset();
        in_valid = '0;
        resetn   = 1'b0;
        @(negedge clock);
        #1;
        resetn   = 1'b1;
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [63:0] ord;
        logic [1:0]  v;
        logic [63:0] o0, o1;

        repeat (2) @(negedge clock);
        #1;
        chk("reset_valid", 192'(out_valid), 192'(0));
        chk("reset_level", 192'(level), 192'(0));
        chk("reset_overflow", 192'(overflow), 192'(0));
        resetn = 1'b1;

        // Single stream with the consumer always ready
        drive(2'b01, 64'd0, 64'd0, 1'b1);
        chk("single_first", 192'(out_order), 192'(0));
        drive(2'b01, 64'd1, 64'd0, 1'b1);
        chk("single_level", 192'(level), 192'(1));
        drive(2'b01, 64'd2, 64'd0, 1'b1);
        idle(1, 1'b1);
        chk("single_drained", 192'(level), 192'(0));

        // Compaction with a gap in the valid mask
        drive(2'b11, 64'd5, 64'd6, 1'b0);
        drive(2'b10, 64'd99, 64'd7, 1'b0);
        chk("compact_level", 192'(level), 192'(3));
        chk("compact_head", 192'(out_order), 192'(5));
        idle(3, 1'b1);
        chk("compact_drained", 192'(level), 192'(0));

        // Fill to DEPTH, then overflow with a fifth group
        for (int i = 0; i < 4; i++) drive(2'b11, 64'(20 + 2*i), 64'(21 + 2*i), 1'b0);
        chk("full_level", 192'(level), 192'(8));
        chk("full_no_overflow", 192'(overflow), 192'(0));
        drive(2'b11, 64'd28, 64'd29, 1'b0);
        chk("overflow_set", 192'(overflow), 192'(1));
        chk("overflow_level", 192'(level), 192'(8));
        idle(8, 1'b1);
        chk("overflow_drained", 192'(level), 192'(0));
        chk("overflow_sticky", 192'(overflow), 192'(1));

        // Full boundary: level 7 plus a two-wide group
        do_reset();
        for (int i = 0; i < 3; i++) drive(2'b11, 64'(40 + 2*i), 64'(41 + 2*i), 1'b0);
        drive(2'b01, 64'd46, 64'd0, 1'b0);
        chk("boundary_level7", 192'(level), 192'(7));
        drive(2'b11, 64'd47, 64'd48, 1'b0);
        chk("boundary_drop", 192'(overflow), 192'(1));
        chk("boundary_drop_level", 192'(level), 192'(7));
        do_reset();
        for (int i = 0; i < 3; i++) drive(2'b11, 64'(50 + 2*i), 64'(51 + 2*i), 1'b0);
        drive(2'b01, 64'd56, 64'd0, 1'b0);
        drive(2'b11, 64'd57, 64'd58, 1'b1);
        chk("boundary_accept_level", 192'(level), 192'(8));
        chk("boundary_accept_ovf", 192'(overflow), 192'(0));
        idle(9, 1'b1);

        // Wrap-around: 40 single entries streamed through
        for (int i = 0; i < 40; i++) drive(2'b01, 64'(100 + i), 64'd0, 1'b1);
        idle(2, 1'b1);
        chk("wrap_overflow", 192'(overflow), 192'(0));
        chk("wrap_drained", 192'(level), 192'(0));

        // Reset mid-burst with five entries buffered
        drive(2'b11, 64'd200, 64'd201, 1'b0);
        drive(2'b11, 64'd202, 64'd203, 1'b0);
        drive(2'b01, 64'd204, 64'd0, 1'b0);
        chk("midreset_level5", 192'(level), 192'(5));
        #2;
        resetn   = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        #1;
        chk("midreset_valid", 192'(out_valid), 192'(0));
        chk("midreset_level", 192'(level), 192'(0));
        @(negedge clock);
        #1;
        resetn = 1'b1;
        idle(3, 1'b1);
        chk("midreset_nostale", 192'(out_valid), 192'(0));

        // Order gap 10 -> 12
        drive(2'b01, 64'd10, 64'd0, 1'b0);
`ifdef RVFI_SERIALIZE_ORDER_CHECK_EN
        chk("order_ok", 192'(order_error), 192'(0));
`endif
        drive(2'b01, 64'd12, 64'd0, 1'b0);
`ifdef RVFI_SERIALIZE_ORDER_CHECK_EN
        chk("order_gap", 192'(order_error), 192'(1));
`endif
        idle(3, 1'b1);

        // Random traffic: first with heavy backpressure, then mostly ready
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            ord = 64'd1000;
            for (int c = 0; c < 300; c++) begin
                v  = 2'($urandom());
                o0 = ord;
                if (v[0]) ord = ord + 64'd1;
                o1 = ord;
                if (v[1]) ord = ord + 64'd1;
                if ($urandom_range(0, 31) == 0) ord = ord + 64'd3;
                drive(v, o0, o1, (phase == 0) ? ($urandom_range(0, 9) < 5)
                                              : ($urandom_range(0, 9) < 9));
            end
            idle(DEPTH + 1, 1'b1);
            chk("random_drained", 192'(level), 192'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
